// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared state encoding, block type codes and default widths for the layer dispatcher
package dispatch_pkg;
  localparam int LEN_W_DEF = 32;
  localparam int LAYER_W_DEF = 8;
  localparam logic [1:0] BT_NONE = 2'b00;
  localparam logic [1:0] BT_FWD = 2'b01;
  localparam logic [1:0] BT_BWD = 2'b10;
  localparam logic [1:0] BT_BOTH = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/engine_issue_slot.sv
// engine_issue_slot: holds one block descriptor until the engine accepts it, then tracks it as pending until done
module engine_issue_slot
  import dispatch_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             abort_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [1:0]       type_i,
  input  logic             ready_i,
  input  logic             done_i,
  output logic             valid_o,
  output logic [LEN_W-1:0] start_o,
  output logic [LEN_W-1:0] len_o,
  output logic [1:0]       type_o,
  output logic             pending_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      pending_o <= 1'b0;
      start_o <= '0;
      len_o <= '0;
      type_o <= '0;
    end else if (abort_i) begin
      valid_o <= 1'b0;
      pending_o <= 1'b0;
    end else begin
      if (load_i) begin
        valid_o <= 1'b1;
        start_o <= start_i;
        len_o <= len_i;
        type_o <= type_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
        pending_o <= 1'b1;
      end
      if (done_i && pending_o) pending_o <= 1'b0;
    end
  end
endmodule

// File: rtl/layer_block_dispatcher.sv
// layer_block_dispatcher: walks the layer table, loads the intra-layer scheduler and issues its block pairs to two engines
module layer_block_dispatcher
  import dispatch_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int LAYER_W = LAYER_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [LAYER_W-1:0] num_layers_i,
  output logic               cfg_req_o,
  output logic [LAYER_W-1:0] cfg_layer_o,
  input  logic               cfg_valid_i,
  input  logic [LEN_W-1:0]   cfg_fwd_len_i,
  input  logic [LEN_W-1:0]   cfg_bwd_len_i,
  input  logic [LEN_W-1:0]   cfg_fwd_bp_i,
  input  logic [LEN_W-1:0]   cfg_bwd_bp_i,
  output logic               sched_clear_o,
  output logic [LEN_W-1:0]   forward_length_o,
  output logic [LEN_W-1:0]   backward_length_o,
  output logic [LEN_W-1:0]   forward_breakpoint_o,
  output logic [LEN_W-1:0]   backward_breakpoint_o,
  output logic               block_finish_valid_o,
  input  logic [LEN_W-1:0]   block0_start_i,
  input  logic [LEN_W-1:0]   block0_length_i,
  input  logic [LEN_W-1:0]   block1_start_i,
  input  logic [LEN_W-1:0]   block1_length_i,
  input  logic [1:0]         block_type_i,
  output logic               eng0_valid_o,
  input  logic               eng0_ready_i,
  output logic [LEN_W-1:0]   eng0_start_o,
  output logic [LEN_W-1:0]   eng0_len_o,
  output logic [1:0]         eng0_type_o,
  input  logic               eng0_done_i,
  output logic               eng1_valid_o,
  input  logic               eng1_ready_i,
  output logic [LEN_W-1:0]   eng1_start_o,
  output logic [LEN_W-1:0]   eng1_len_o,
  output logic [1:0]         eng1_type_o,
  input  logic               eng1_done_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [LAYER_W-1:0] layer_idx_o
);
  state_t state, state_d;
  logic settle_wait, evaluate, exhausted, last, load0, load1, pend0, pend1;
  logic clr_d, fin_d, done_d;
  logic [LAYER_W-1:0] num_layers, layer_idx, layer_inc;
  assign layer_inc = layer_idx + LAYER_W'(1);
  assign last = layer_inc == num_layers;
  assign evaluate = state == ST_SETTLE && !settle_wait && !abort_i;
  assign exhausted = block_type_i == BT_NONE;
  assign load0 = evaluate && !exhausted && |block0_length_i;
  assign load1 = evaluate && !exhausted && |block1_length_i;
  assign busy_o = state != ST_IDLE;
  assign cfg_req_o = state == ST_FETCH;
  assign cfg_layer_o = layer_idx;
  assign layer_idx_o = layer_idx;
  always_comb begin
    state_d = state;
    clr_d = 1'b0;
    fin_d = 1'b0;
    done_d = 1'b0;
    case (state)
      ST_IDLE: begin
        state_d = start_i && num_layers_i != '0 ? ST_FETCH : ST_IDLE;
        done_d = start_i && num_layers_i == '0;
      end
      ST_FETCH: begin
        state_d = cfg_valid_i ? ST_SETTLE : ST_FETCH;
        clr_d = cfg_valid_i;
      end
      ST_SETTLE: begin
        state_d = !evaluate ? ST_SETTLE :
                  exhausted ? (last ? ST_DONE : ST_FETCH) :
                  (load0 || load1) ? ST_DISPATCH : ST_SETTLE;
        fin_d = evaluate && !exhausted && !load0 && !load1;
        done_d = evaluate && exhausted && last;
      end
      ST_DISPATCH: state_d = (!eng0_valid_o || eng0_ready_i) && (!eng1_valid_o || eng1_ready_i) ? ST_WAIT : ST_DISPATCH;
      ST_WAIT: begin
        state_d = pend0 || pend1 ? ST_WAIT : ST_SETTLE;
        fin_d = !pend0 && !pend1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      clr_d = 1'b0;
      fin_d = 1'b0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      settle_wait <= 1'b0;
      sched_clear_o <= 1'b0;
      block_finish_valid_o <= 1'b0;
      done_o <= 1'b0;
      num_layers <= '0;
      layer_idx <= '0;
      forward_length_o <= '0;
      backward_length_o <= '0;
      forward_breakpoint_o <= '0;
      backward_breakpoint_o <= '0;
    end else begin
      state <= state_d;
      settle_wait <= clr_d || fin_d;
      sched_clear_o <= clr_d;
      block_finish_valid_o <= fin_d;
      done_o <= done_d;
      if (state == ST_IDLE && start_i && !abort_i) begin
        num_layers <= num_layers_i;
        layer_idx <= '0;
      end
      if (evaluate && exhausted) layer_idx <= layer_inc;
      if (clr_d) begin
        forward_length_o <= cfg_fwd_len_i;
        backward_length_o <= cfg_bwd_len_i;
        forward_breakpoint_o <= cfg_fwd_bp_i;
        backward_breakpoint_o <= cfg_bwd_bp_i;
      end
    end
  end
  engine_issue_slot #(.LEN_W(LEN_W)) u_eng0 (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .abort_i(abort_i),
    .load_i(load0),
    .start_i(block0_start_i),
    .len_i(block0_length_i),
    .type_i(block_type_i),
    .ready_i(eng0_ready_i),
    .done_i(eng0_done_i),
    .valid_o(eng0_valid_o),
    .start_o(eng0_start_o),
    .len_o(eng0_len_o),
    .type_o(eng0_type_o),
    .pending_o(pend0)
  );
  engine_issue_slot #(.LEN_W(LEN_W)) u_eng1 (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .abort_i(abort_i),
    .load_i(load1),
    .start_i(block1_start_i),
    .len_i(block1_length_i),
    .type_i(block_type_i),
    .ready_i(eng1_ready_i),
    .done_i(eng1_done_i),
    .valid_o(eng1_valid_o),
    .start_o(eng1_start_o),
    .len_o(eng1_len_o),
    .type_o(eng1_type_o),
    .pending_o(pend1)
  );
endmodule
